// File: rtl/cpu_alu_pkg.sv
// Shared ALU definitions: operand width, divider FSM states and counter width.
package cpu_alu_pkg;
  localparam int XLEN      = 32;
  localparam int DIV_CNT_W = $clog2(XLEN + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } div_state_t;
endpackage

// File: rtl/div_sub_stage.sv
// One restoring-division step: subtract divisor from the shifted partial
// remainder when it fits, reporting the quotient bit.
module div_sub_stage #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic             qbit
);
  logic [WIDTH-1:0] w_diff;
  logic             w_borrow;

  // A set top bit means rem >= 2^WIDTH > divisor, so the WIDTH+1-bit borrow
  // reduces to this bit OR the borrow of the low WIDTH bits.
  assign {w_borrow, w_diff} = {1'b0, rem[WIDTH-1:0]} - {1'b0, divisor};
  assign qbit               = rem[WIDTH] | ~w_borrow;
  assign next_rem           = qbit ? w_diff : rem[WIDTH-1:0];
endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider with start/busy/done handshake.
// Define DIV_SIGNED_EN to build signed (truncate-toward-zero) support.
module seq_divider
  import cpu_alu_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  div_state_t       r_state;
  div_state_t       w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_rem;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem_out;
  logic             r_dz;

  logic [WIDTH-1:0] w_dvd_in;
  logic [WIDTH-1:0] w_dvs_in;
  logic [WIDTH-1:0] w_next_rem;
  logic             w_qbit;
  logic             w_fin_dz;
  logic [WIDTH-1:0] w_fin_q;
  logic [WIDTH-1:0] w_fin_r;

`ifdef DIV_SIGNED_EN
  logic r_neg_q;
  logic r_neg_r;
  logic w_neg_dvd;
  logic w_neg_dvs;

  assign w_neg_dvd = signed_op & dividend[WIDTH-1];
  assign w_neg_dvs = signed_op & divisor[WIDTH-1];
  // Divide-by-zero keeps the raw dividend so it can be returned as remainder.
  assign w_dvd_in  = (w_neg_dvd && (divisor != '0)) ? -dividend : dividend;
  assign w_dvs_in  = w_neg_dvs ? -divisor : divisor;
  assign w_fin_dz  = (r_dvs == '0);
  assign w_fin_q   = w_fin_dz ? '1    : (r_neg_q ? -r_dvd : r_dvd);
  assign w_fin_r   = w_fin_dz ? r_dvd : (r_neg_r ? -r_rem : r_rem);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_neg_q <= w_neg_dvd ^ w_neg_dvs;
      r_neg_r <= w_neg_dvd;
    end
  end
`else
  logic w_unused_signed;

  assign w_unused_signed = signed_op;
  assign w_dvd_in        = dividend;
  assign w_dvs_in        = divisor;
  assign w_fin_dz        = (r_dvs == '0);
  assign w_fin_q         = w_fin_dz ? '1    : r_dvd;
  assign w_fin_r         = w_fin_dz ? r_dvd : r_rem;
`endif

  div_sub_stage #(.WIDTH(WIDTH)) u_sub (
    .rem      ({r_rem, r_dvd[WIDTH-1]}),
    .divisor  (r_dvs),
    .next_rem (w_next_rem),
    .qbit     (w_qbit)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (start) w_state_next = (divisor == '0) ? FIN : RUN;
      RUN:  if (r_cnt == CNT_W'(WIDTH - 1)) w_state_next = FIN;
      FIN:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_cnt     <= '0;
      r_dvd     <= '0;
      r_dvs     <= '0;
      r_rem     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_quot    <= '0;
      r_rem_out <= '0;
      r_dz      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_dvd  <= w_dvd_in;
            r_dvs  <= w_dvs_in;
            r_rem  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
          end
        end
        RUN: begin
          // The dividend register doubles as the quotient shift register.
          r_rem <= w_next_rem;
          r_dvd <= {r_dvd[WIDTH-2:0], w_qbit};
          r_cnt <= r_cnt + 1'b1;
        end
        FIN: begin
          r_busy    <= 1'b0;
          r_done    <= 1'b1;
          r_quot    <= w_fin_q;
          r_rem_out <= w_fin_r;
          r_dz      <= w_fin_dz;
        end
        default: ;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign quotient  = r_quot;
  assign remainder = r_rem_out;
  assign div_zero  = r_dz;
endmodule
